// File: rtl/dmem_pkg.sv
// dmem_pkg
//   Shared types and helpers for the data-memory responder slice.
//   - dmem_state_t : responder FSM states (idle / counting wait states / response held)
//   - dmem_req_t   : one request beat as captured from the req_* port group
//   - LAT_W        : width of the wait-state counter (covers LATENCY up to 15)
//   - merge_lanes  : byte-lane write merge used by the RAM write path
package dmem_pkg;

  localparam int LAT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } dmem_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dmem_req_t;

  // Replace only the enabled byte lanes of old_word with the matching lanes of
  // wdata; lane i is bits [8i+7:8i]. An all-zero enable returns old_word intact.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = wdata[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_wait_ctr.sv
// dmem_wait_ctr
//   Loadable down-counter that paces the responder's wait states.
//   Ports:
//     clk        in   clock, all state changes on posedge
//     reset      in   synchronous, active-high; clears the count
//     load       in   load load_value on this edge (takes priority over counting)
//     load_value in   LAT_W-bit start value
//     value      out  current count
//     done       out  high while value == 1, i.e. the final wait edge is next
module dmem_wait_ctr
  import dmem_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [LAT_W-1:0] load_value,
  output logic [LAT_W-1:0] value,
  output logic             done
);

  // Count down toward zero and park there; a load restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (value != '0) begin
      value <= value - 1'b1;
    end
  end

  assign done = (value == LAT_W'(1));

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
//   Target end of the processor data-memory port: a word-organised RAM behind
//   a valid/ready request channel and a valid/ready response channel, with
//   byte-lane writes, programmable wait states and error responses. Only one
//   request is outstanding at a time.
//   Parameters:
//     DEPTH_WORDS  RAM depth in 32-bit words (byte addresses 0 .. 4*DEPTH_WORDS-1)
//     LATENCY      edges from the accepting edge to rsp_valid high, 1..15
//   Ports:
//     clk        in   clock
//     reset      in   synchronous, active-high; drops any pending response
//     req_valid  in   request present
//     req_ready  out  responder can accept (idle and not in reset)
//     req_we     in   1 = write, 0 = read
//     req_addr   in   byte address
//     req_wdata  in   write data
//     req_be     in   byte enables (writes only)
//     rsp_valid  out  response present
//     rsp_ready  in   consumer takes the response
//     rsp_rdata  out  read word; 0 for writes and errors
//     rsp_err    out  misaligned or out-of-range access
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int               IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0]      DEPTH_LIM = 30'(DEPTH_WORDS);
  localparam logic [LAT_W-1:0] WAIT_LOAD = LAT_W'(LATENCY - 1);

  dmem_req_t        req;
  dmem_state_t      state;
  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             addr_err;
  logic             ctr_load;
  logic [LAT_W-1:0] ctr_value;
  logic             ctr_done;

  assign req = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};

  // Gating with reset keeps a request held across reset from being taken.
  assign req_ready = (state == S_IDLE) & ~reset;
  assign accept    = req_valid & req_ready;

  // Word index is compared in full so high address bits cannot alias into range.
  assign addr_err = (req.addr[1:0] != 2'b00) || (req.addr[31:2] >= DEPTH_LIM);
  assign idx      = req.addr[IDX_W+1:2];

  // With single-edge latency the FSM skips S_WAIT, so the counter stays idle.
  assign ctr_load = accept && (LATENCY > 1);

  dmem_wait_ctr u_wait_ctr (
    .clk        (clk),
    .reset      (reset),
    .load       (ctr_load),
    .load_value (WAIT_LOAD),
    .value      (ctr_value),
    .done       (ctr_done)
  );

  // RAM write port. The write commits on the accepting edge, so a later reset
  // that drops the response does not undo it. Contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && req.we && !addr_err) begin
      mem[idx] <= merge_lanes(mem[idx], req.wdata, req.be);
    end
  end

  // Responder FSM. Read data and error are captured on the accepting edge and
  // held until the response handshake; they are left untouched afterwards so
  // consumers must qualify them with rsp_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            rsp_err   <= addr_err;
            rsp_rdata <= (addr_err || req.we) ? 32'h0 : mem[idx];
            if (LATENCY <= 1) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // The zero-count term only matters if the counter was somehow left
          // empty; it keeps the FSM from stalling in S_WAIT forever.
          if (ctr_done || (ctr_value == '0)) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Self-checking bench for dmem_responder. A behavioural memory model (plain
//   array plus per-byte "written" mask) supplies every expected read value and
//   error flag; latency and handshake timing are checked against LATENCY.
module tb_dmem_responder;

  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks;
  int failures;

  logic [31:0] model_mem   [DEPTH];
  logic [3:0]  model_kmask [DEPTH];

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LATENCY)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: applies one access to the model memory and returns the
  // expected rdata/err, plus whether every byte of a read word is defined.
  task automatic model_access(input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              output logic [31:0] exp_rdata, output logic exp_err,
                              output bit exp_known);
    longint unsigned word;
    word      = longint'(addr) / 4;
    exp_err   = ((addr % 4) != 0) || (word >= DEPTH);
    exp_rdata = 32'h0;
    exp_known = 1'b1;
    if (!exp_err) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) begin
            model_mem[word][8*i +: 8] = wdata[8*i +: 8];
            model_kmask[word][i]      = 1'b1;
          end
        end
      end else begin
        exp_rdata = model_mem[word];
        exp_known = (model_kmask[word] == 4'hF);
      end
    end
  endtask

  // Drives one request, waits (bounded) for acceptance and the response, and
  // reports what it saw. With hold = 0 it also completes the response
  // handshake and reports whether the responder went straight back to ready.
  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input bit hold,
                               output int lat, output logic [31:0] rdata,
                               output logic err, output bit ready_after);
    int n;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    rsp_ready = 1'b0;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata       = rsp_rdata;
    err         = rsp_err;
    ready_after = 1'b0;
    if (!hold) begin
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready   = 1'b0;
      ready_after = (req_ready === 1'b1) && (rsp_valid === 1'b0);
    end
  endtask

  task automatic test_reset();
    bit seen_valid;
    reset     = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'd4;
    req_wdata = 32'hDEAD_BEEF;
    req_be    = 4'hF;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_ready_low: got %b expected 0", req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got valid=%b rdata=%h err=%b expected 0/0/0",
               rsp_valid, rsp_rdata, rsp_err);
    end
    reset     = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_release: got ready=%b valid=%b expected 1/0",
               req_ready, rsp_valid);
    end
    seen_valid = 1'b0;
    for (int i = 0; i < LATENCY + 3; i++) begin
      @(posedge clk); #1;
      if (rsp_valid === 1'b1) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid) begin
      failures++;
      $display("[TB] FAIL reset_no_accept: got rsp_valid=1 expected 0 after reset");
    end
  endtask

  task automatic test_write_read();
    int lat;
    logic [31:0] rd, er;
    logic e, ee;
    bit ra, ek;
    model_access(1'b1, 32'd100, 32'd25, 4'hF, er, ee, ek);
    applyStimulus(1'b1, 32'd100, 32'd25, 4'hF, 1'b0, lat, rd, e, ra);
    checks++;
    if (lat != LATENCY || rd !== 32'h0 || e !== 1'b0 || !ra) begin
      failures++;
      $display("[TB] FAIL wr_write: got lat=%0d rdata=%h err=%b ready_after=%b expected lat=%0d rdata=0 err=0 ready_after=1",
               lat, rd, e, ra, LATENCY);
    end
    model_access(1'b0, 32'd100, 32'h0, 4'h0, er, ee, ek);
    applyStimulus(1'b0, 32'd100, 32'h0, 4'h0, 1'b0, lat, rd, e, ra);
    checks++;
    if (lat != LATENCY || rd !== 32'h19 || rd !== er || e !== 1'b0) begin
      failures++;
      $display("[TB] FAIL wr_read: got lat=%0d rdata=%h err=%b expected lat=%0d rdata=00000019 err=0",
               lat, rd, e, LATENCY);
    end
  endtask

  task automatic test_byte_lanes();
    int lat;
    logic [31:0] rd, er;
    logic e, ee;
    bit ra, ek;
    model_access(1'b1, 32'd0, 32'hAABB_CCDD, 4'hF, er, ee, ek);
    applyStimulus(1'b1, 32'd0, 32'hAABB_CCDD, 4'hF, 1'b0, lat, rd, e, ra);
    model_access(1'b1, 32'd0, 32'h1122_3344, 4'b0101, er, ee, ek);
    applyStimulus(1'b1, 32'd0, 32'h1122_3344, 4'b0101, 1'b0, lat, rd, e, ra);
    model_access(1'b0, 32'd0, 32'h0, 4'h0, er, ee, ek);
    applyStimulus(1'b0, 32'd0, 32'h0, 4'h0, 1'b0, lat, rd, e, ra);
    checks++;
    if (rd !== 32'hAA22_CC44 || rd !== er || e !== 1'b0) begin
      failures++;
      $display("[TB] FAIL lanes_merge: got rdata=%h err=%b expected aa22cc44 err=0", rd, e);
    end
    model_access(1'b1, 32'd0, 32'hFFFF_FFFF, 4'b0000, er, ee, ek);
    applyStimulus(1'b1, 32'd0, 32'hFFFF_FFFF, 4'b0000, 1'b0, lat, rd, e, ra);
    checks++;
    if (e !== 1'b0) begin
      failures++;
      $display("[TB] FAIL lanes_be0_err: got err=%b expected 0", e);
    end
    model_access(1'b0, 32'd0, 32'h0, 4'h0, er, ee, ek);
    applyStimulus(1'b0, 32'd0, 32'h0, 4'h0, 1'b0, lat, rd, e, ra);
    checks++;
    if (rd !== er) begin
      failures++;
      $display("[TB] FAIL lanes_be0_noop: got rdata=%h expected %h", rd, er);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] rd, er;
    logic e, ee;
    bit ra, ek;
    model_access(1'b0, 32'd100, 32'h0, 4'h0, er, ee, ek);
    applyStimulus(1'b0, 32'd100, 32'h0, 4'h0, 1'b1, lat, rd, e, ra);
    checks++;
    if (lat != LATENCY || rd !== er) begin
      failures++;
      $display("[TB] FAIL bp_first: got lat=%0d rdata=%h expected lat=%0d rdata=%h",
               lat, rd, LATENCY, er);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== er || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL bp_hold_%0d: got valid=%b rdata=%h err=%b ready=%b expected 1/%h/0/0",
                 i, rsp_valid, rsp_rdata, rsp_err, req_ready, er);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_release: got ready=%b valid=%b expected 1/0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_errors();
    int lat;
    logic [31:0] rd, er;
    logic e, ee;
    bit ra, ek;
    logic [31:0] bad_addr [4];
    logic [31:0] bad_data [4];
    bad_addr[0] = 32'd102;             bad_data[0] = 32'h0;
    bad_addr[1] = 32'(4 * DEPTH);      bad_data[1] = 32'h5555_AAAA;
    bad_addr[2] = 32'd2;               bad_data[2] = 32'h1234_5678;
    bad_addr[3] = 32'h8000_0000;       bad_data[3] = 32'hCAFE_F00D;
    model_access(1'b0, bad_addr[0], 32'h0, 4'h0, er, ee, ek);
    applyStimulus(1'b0, bad_addr[0], 32'h0, 4'h0, 1'b0, lat, rd, e, ra);
    checks++;
    if (e !== 1'b1 || rd !== 32'h0 || e !== ee || lat != LATENCY) begin
      failures++;
      $display("[TB] FAIL err_misaligned_read: got err=%b rdata=%h lat=%0d expected err=1 rdata=0 lat=%0d",
               e, rd, lat, LATENCY);
    end
    for (int k = 1; k < 4; k++) begin
      model_access(1'b1, bad_addr[k], bad_data[k], 4'hF, er, ee, ek);
      applyStimulus(1'b1, bad_addr[k], bad_data[k], 4'hF, 1'b0, lat, rd, e, ra);
      checks++;
      if (e !== 1'b1 || rd !== 32'h0 || e !== ee) begin
        failures++;
        $display("[TB] FAIL err_write_%0d: got err=%b rdata=%h expected err=1 rdata=0", k, e, rd);
      end
    end
    model_access(1'b0, 32'd0, 32'h0, 4'h0, er, ee, ek);
    applyStimulus(1'b0, 32'd0, 32'h0, 4'h0, 1'b0, lat, rd, e, ra);
    checks++;
    if (rd !== er || e !== 1'b0) begin
      failures++;
      $display("[TB] FAIL err_ram_unchanged: got rdata=%h err=%b expected %h err=0", rd, e, er);
    end
    model_access(1'b1, 32'(4 * DEPTH - 4), 32'h0BAD_CAFE, 4'hF, er, ee, ek);
    applyStimulus(1'b1, 32'(4 * DEPTH - 4), 32'h0BAD_CAFE, 4'hF, 1'b0, lat, rd, e, ra);
    model_access(1'b0, 32'(4 * DEPTH - 4), 32'h0, 4'h0, er, ee, ek);
    applyStimulus(1'b0, 32'(4 * DEPTH - 4), 32'h0, 4'h0, 1'b0, lat, rd, e, ra);
    checks++;
    if (rd !== er || e !== 1'b0) begin
      failures++;
      $display("[TB] FAIL err_last_word: got rdata=%h err=%b expected %h err=0", rd, e, er);
    end
  endtask

  task automatic test_reset_in_wait();
    int lat;
    logic [31:0] rd, er;
    logic e, ee;
    bit ra, ek, seen_valid;
    int n;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'd8;
    req_wdata = 32'd7;
    req_be    = 4'hF;
    rsp_ready = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    model_access(1'b1, 32'd8, 32'd7, 4'hF, er, ee, ek);
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset     = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rstwait_idle: got valid=%b ready=%b expected 0/1", rsp_valid, req_ready);
    end
    seen_valid = 1'b0;
    for (int i = 0; i < LATENCY + 2; i++) begin
      @(posedge clk); #1;
      if (rsp_valid === 1'b1) seen_valid = 1'b1;
    end
    rsp_ready = 1'b0;
    checks++;
    if (seen_valid) begin
      failures++;
      $display("[TB] FAIL rstwait_dropped: got rsp_valid=1 expected 0");
    end
    model_access(1'b0, 32'd8, 32'h0, 4'h0, er, ee, ek);
    applyStimulus(1'b0, 32'd8, 32'h0, 4'h0, 1'b0, lat, rd, e, ra);
    checks++;
    if (rd !== 32'd7 || rd !== er || e !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rstwait_committed: got rdata=%h err=%b expected 00000007 err=0", rd, e);
    end
  endtask

  task automatic test_back_to_back();
    int acc_cycles[$];
    logic [31:0] er;
    logic ee;
    bit ek;
    model_access(1'b0, 32'd100, 32'h0, 4'h0, er, ee, ek);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'd100;
    req_wdata = 32'h0;
    req_be    = 4'h0;
    rsp_ready = 1'b1;
    for (int t = 0; t < 6 * (LATENCY + 1); t++) begin
      if (req_ready === 1'b1) acc_cycles.push_back(t);
      if (rsp_valid === 1'b1) begin
        checks++;
        if (rsp_rdata !== er || rsp_err !== 1'b0) begin
          failures++;
          $display("[TB] FAIL b2b_data_t%0d: got rdata=%h err=%b expected %h err=0",
                   t, rsp_rdata, rsp_err, er);
        end
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (req_ready === 1'b1 && rsp_valid !== 1'b1) break;
      @(posedge clk); #1;
    end
    rsp_ready = 1'b0;
    checks++;
    if (acc_cycles.size() < 5) begin
      failures++;
      $display("[TB] FAIL b2b_count: got %0d accepts expected at least 5", acc_cycles.size());
    end
    for (int i = 1; i < acc_cycles.size(); i++) begin
      checks++;
      if (acc_cycles[i] - acc_cycles[i-1] != LATENCY + 1) begin
        failures++;
        $display("[TB] FAIL b2b_gap_%0d: got %0d cycles expected %0d",
                 i, acc_cycles[i] - acc_cycles[i-1], LATENCY + 1);
      end
    end
  endtask

  task automatic test_random();
    int lat;
    logic [31:0] rd, er, addr, wdata;
    logic e, ee, we;
    logic [3:0] be;
    bit ra, ek;
    int sel;
    for (int n = 0; n < 80; n++) begin
      we    = 1'($urandom);
      wdata = $urandom;
      be    = 4'($urandom);
      sel   = $urandom_range(0, 9);
      if (sel == 0)      addr = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
      else if (sel == 1) addr = 32'(4 * DEPTH) + 32'($urandom_range(0, 4095) * 4);
      else               addr = 32'($urandom_range(0, 31) * 4);
      model_access(we, addr, wdata, be, er, ee, ek);
      applyStimulus(we, addr, wdata, be, 1'b0, lat, rd, e, ra);
      checks++;
      if (lat != LATENCY || e !== ee || !ra || (ek && rd !== er)) begin
        failures++;
        $display("[TB] FAIL rand_%0d: we=%b addr=%h got lat=%0d err=%b rdata=%h ready_after=%b expected lat=%0d err=%b rdata=%h",
                 n, we, addr, lat, e, rd, ra, LATENCY, ee, er);
      end
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_be    = 4'h0;
    rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i]   = 32'h0;
      model_kmask[i] = 4'h0;
    end
    $display("[TB] starting dmem_responder bench, LATENCY=%0d DEPTH=%0d", LATENCY, DEPTH);
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_backpressure();
    test_errors();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
